// File: rtl/overlay_pkg.sv
// overlay_pkg
// Shared definitions for the sprite overlay layer: colour constants,
// configuration register addresses, ctrl bit positions, the row-prefetch
// state enum and the per-axis bounce helper used by the motion logic.
package overlay_pkg;

    localparam logic [5:0] TRANSPARENT = 6'b100001;
    localparam logic [5:0] BLACK       = 6'b000000;
    localparam logic [5:0] GOLD        = 6'b110110;
    localparam logic [5:0] RED         = 6'b110000;
    localparam logic [5:0] WHITE       = 6'b111111;

    localparam logic [1:0] CFG_XPOS   = 2'd0;
    localparam logic [1:0] CFG_YPOS   = 2'd1;
    localparam logic [1:0] CFG_COLOUR = 2'd2;
    localparam logic [1:0] CFG_CTRL   = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_MOTION = 1;
    localparam int CTRL_XDIR   = 2;
    localparam int CTRL_YDIR   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // One motion step along one axis. Returns {new_dir, new_pos}; dir 1 means
    // moving towards zero. Positive moves clamp at lim, negative ones at 0,
    // and the direction flips whenever a clamp happens.
    function automatic logic [10:0] bounce_step(
        input logic [9:0]  pos,
        input logic        neg,
        input logic [10:0] step,
        input logic [9:0]  lim
    );
        logic [10:0] fwd;
        fwd = {1'b0, pos} + step;
        if (!neg) begin
            if (fwd > {1'b0, lim})
                return {1'b1, lim};
            return {1'b0, fwd[9:0]};
        end
        if ({1'b0, pos} < step)
            return {1'b0, 10'd0};
        return {1'b1, pos - step[9:0]};
    endfunction

endpackage

// File: rtl/sprite_motion.sv
// sprite_motion
// Register set for one sprite slot: position, colour and ctrl, plus the
// per-frame bounce motion. A config write landing on the frame_start cycle
// overrides motion for the written register only.
// Ports:
//   clk, rst        pixel clock, synchronous active-high reset
//   frame_start     one-cycle pulse that advances motion
//   we, addr, data  register write already decoded for this slot
//   xpos, ypos      current sprite position
//   colour          sprite colour
//   enable          ctrl enable bit
module sprite_motion
    import overlay_pkg::*;
#(
    parameter int SPR_W      = 48,
    parameter int SPR_H      = 45,
    parameter int SCALE_LOG2 = 0,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int STEP       = 1
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [9:0] data,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic [5:0] colour,
    output logic       enable
);

    localparam logic [9:0]  X_MAX  = 10'(H_RES - (SPR_W << SCALE_LOG2));
    localparam logic [9:0]  Y_MAX  = 10'(V_RES - (SPR_H << SCALE_LOG2));
    localparam logic [10:0] STEP11 = 11'(STEP);

    logic [3:0]  ctrl;
    logic [10:0] x_move;
    logic [10:0] y_move;

    assign enable = ctrl[CTRL_EN];
    assign x_move = bounce_step(xpos, ctrl[CTRL_XDIR], STEP11, X_MAX);
    assign y_move = bounce_step(ypos, ctrl[CTRL_YDIR], STEP11, Y_MAX);

    // The write case comes after the motion update so that, for the same
    // register, the last non-blocking assignment (the write) takes effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            xpos   <= '0;
            ypos   <= '0;
            colour <= GOLD;
            ctrl   <= '0;
        end else begin
            if (frame_start && ctrl[CTRL_MOTION]) begin
                xpos            <= x_move[9:0];
                ypos            <= y_move[9:0];
                ctrl[CTRL_XDIR] <= x_move[10];
                ctrl[CTRL_YDIR] <= y_move[10];
            end
            if (we) begin
                case (addr)
                    CFG_XPOS:   xpos   <= data;
                    CFG_YPOS:   ypos   <= data;
                    CFG_COLOUR: colour <= data[5:0];
                    CFG_CTRL:   ctrl   <= data[3:0];
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: rtl/sprite_layer.sv
// sprite_layer
// Overlay of NUM_SPR copies of one shared monochrome bitmap, each with its
// own position, colour and optional bounce motion, scaled by 2^SCALE_LOG2.
// Bitmap rows for the next line are prefetched from an external ROM during
// horizontal blanking into one row buffer per slot.
// Ports:
//   clk, rst                   pixel clock, synchronous active-high reset
//   x, y, active               current pixel position and visible flag
//   line_end, frame_start      timing pulses from the VGA generator
//   cfg_we/sel/addr/data       per-slot register writes
//   rom_addr, rom_data         bitmap ROM row request / row one cycle later
//   rgb                        registered pixel or transparent key
module sprite_layer
    import overlay_pkg::*;
#(
    parameter int NUM_SPR    = 3,
    parameter int SPR_W      = 48,
    parameter int SPR_H      = 45,
    parameter int SCALE_LOG2 = 0,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int V_TOTAL    = 525,
    parameter int STEP       = 1,
    localparam int SEL_W     = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
    localparam int ROW_W     = (SPR_H > 1) ? $clog2(SPR_H) : 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             active,
    input  logic             line_end,
    input  logic             frame_start,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [1:0]       cfg_addr,
    input  logic [9:0]       cfg_data,
    output logic [ROW_W-1:0] rom_addr,
    input  logic [SPR_W-1:0] rom_data,
    output logic [5:0]       rgb
);

    localparam int          COL_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam logic [10:0] W       = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] SPR_H11 = 11'(SPR_H);

    logic [9:0]       xpos    [NUM_SPR];
    logic [9:0]       ypos    [NUM_SPR];
    logic [5:0]       colour  [NUM_SPR];
    logic             enable  [NUM_SPR];
    logic [SPR_W-1:0] rowbuf  [NUM_SPR];

    fetch_state_t     state;
    logic [SEL_W-1:0] idx;
    logic [9:0]       ny;
    logic             cap_valid;
    logic             cap_hit;
    logic [SEL_W-1:0] cap_idx;
    logic [10:0]      row_off;
    logic             fetch_hit;

    logic [10:0]      x_off   [NUM_SPR];
    logic [COL_W-1:0] x_col   [NUM_SPR];
    logic [NUM_SPR-1:0] slot_hit;
    logic [5:0]       pix_colour;

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_slot
        sprite_motion #(
            .SPR_W      (SPR_W),
            .SPR_H      (SPR_H),
            .SCALE_LOG2 (SCALE_LOG2),
            .H_RES      (H_RES),
            .V_RES      (V_RES),
            .STEP       (STEP)
        ) u_motion (
            .clk         (clk),
            .rst         (rst),
            .frame_start (frame_start),
            .we          (cfg_we && (cfg_sel == SEL_W'(i))),
            .addr        (cfg_addr),
            .data        (cfg_data),
            .xpos        (xpos[i]),
            .ypos        (ypos[i]),
            .colour      (colour[i]),
            .enable      (enable[i])
        );
    end

    // Row request for the slot being fetched this cycle. Driven only from
    // registered state, so the ROM sees a stable address all cycle.
    always_comb begin
        row_off   = ({1'b0, ny} - {1'b0, ypos[idx]}) >> SCALE_LOG2;
        fetch_hit = (state == FETCH) && enable[idx] &&
                    (ny >= ypos[idx]) && (row_off < SPR_H11);
        rom_addr  = fetch_hit ? row_off[ROW_W-1:0] : '0;
    end

    // Prefetch FSM. The request of one cycle is captured on the next, so the
    // last slot lands at the end of DRAIN. A line_end at any time restarts
    // from slot 0; a pending capture still completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            ny        <= '0;
            cap_valid <= 1'b0;
            cap_hit   <= 1'b0;
            cap_idx   <= '0;
            for (int i = 0; i < NUM_SPR; i++)
                rowbuf[i] <= '0;
        end else begin
            cap_valid <= (state == FETCH);
            cap_hit   <= fetch_hit;
            cap_idx   <= idx;
            if (cap_valid)
                rowbuf[cap_idx] <= cap_hit ? rom_data : '0;

            if (line_end) begin
                state <= FETCH;
                idx   <= '0;
                ny    <= (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
            end else begin
                case (state)
                    FETCH: begin
                        if (idx == SEL_W'(NUM_SPR - 1))
                            state <= DRAIN;
                        else
                            idx <= idx + SEL_W'(1);
                    end
                    DRAIN:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Per-slot hit test; iterating downwards lets the lowest index win.
    always_comb begin
        pix_colour = TRANSPARENT;
        for (int i = 0; i < NUM_SPR; i++) begin
            x_off[i]    = {1'b0, x} - {1'b0, xpos[i]};
            x_col[i]    = COL_W'(x_off[i] >> SCALE_LOG2);
            slot_hit[i] = (x >= xpos[i]) && (x_off[i] < W) && rowbuf[i][x_col[i]];
        end
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (slot_hit[i])
                pix_colour = colour[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rgb <= TRANSPARENT;
        else
            rgb <= (active && (|slot_hit)) ? pix_colour : TRANSPARENT;
    end

endmodule

// File: tb/tb_sprite_layer.sv
// tb_sprite_layer
// Directed bench for sprite_layer: reset state, single-sprite rendering,
// priority, scaling (second instance with SCALE_LOG2=1), bounce motion with
// write override, and prefetch restart / reset during DRAIN.
module tb_sprite_layer;
    import overlay_pkg::*;

    localparam int NUM_SPR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x, y;
    logic        active, line_end, frame_start, cfg_we;
    logic [1:0]  cfg_sel;
    logic [1:0]  cfg_addr;
    logic [9:0]  cfg_data;
    logic [5:0]  rom_addr, rom_addr2;
    logic [47:0] rom_data, rom_data2;
    logic [5:0]  rgb, rgb2;

    int checks   = 0;
    int failures = 0;
    int rom_mode = 0;
    logic [5:0] addr_log  [NUM_SPR];
    logic [5:0] addr_log2 [NUM_SPR];

    always #5 clk = ~clk;

    sprite_layer #(.NUM_SPR(NUM_SPR), .SCALE_LOG2(0)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .active(active),
        .line_end(line_end), .frame_start(frame_start),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .rom_addr(rom_addr), .rom_data(rom_data), .rgb(rgb)
    );

    sprite_layer #(.NUM_SPR(NUM_SPR), .SCALE_LOG2(1)) dut2 (
        .clk(clk), .rst(rst), .x(x), .y(y), .active(active),
        .line_end(line_end), .frame_start(frame_start),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .rgb(rgb2)
    );

    // ROM model: row contents depend on the scenario selected by rom_mode.
    function automatic logic [47:0] rom_fn(input int mode, input logic [5:0] a);
        case (mode)
            1:       rom_fn = 48'h1 << (int'(a) % 48);
            2:       rom_fn = 48'hFFFF_FFFF_FFFF;
            3:       rom_fn = (a == 6'd0) ? 48'h1 : ((a == 6'd1) ? 48'h2 : 48'h0);
            4:       rom_fn = 48'h1;
            default: rom_fn = 48'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        rom_data  <= rom_fn(rom_mode, rom_addr);
        rom_data2 <= rom_fn(rom_mode, rom_addr2);
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; x = '0; y = '0; active = 1'b0; line_end = 1'b0;
        frame_start = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int sel, input logic [1:0] a, input int d);
        cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_addr = a; cfg_data = 10'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic prefetch(input int yv);
        y = 10'(yv); line_end = 1'b1;
        tick();
        line_end = 1'b0;
        for (int i = 0; i < NUM_SPR; i++) begin
            addr_log[i]  = rom_addr;
            addr_log2[i] = rom_addr2;
            tick();
        end
        tick();
    endtask

    task automatic pixel(input int xv, output logic [5:0] o, output logic [5:0] o2);
        x = 10'(xv); active = 1'b1;
        tick();
        active = 1'b0;
        o = rgb; o2 = rgb2;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] o, o2;
        int bad;
        do_reset();
        checks++;
        if (rgb !== TRANSPARENT) begin failures++; $display("[TB] FAIL reset_rgb got=%b exp=%b", rgb, TRANSPARENT); end
        checks++;
        if (rom_addr !== 6'd0) begin failures++; $display("[TB] FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        bad = 0;
        for (int ln = 0; ln < 4; ln++) begin
            prefetch(ln);
            for (int i = 0; i < NUM_SPR; i++) if (addr_log[i] !== 6'd0) bad++;
            for (int xv = 0; xv < 80; xv++) begin
                pixel(xv, o, o2);
                if (o !== TRANSPARENT || o2 !== TRANSPARENT) bad++;
            end
        end
        checks++;
        if (bad !== 0) begin failures++; $display("[TB] FAIL reset_idle_frame bad_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_single();
        logic [5:0] o, o2;
        int ks[4] = '{0, 1, 17, 44};
        int bad;
        do_reset();
        rom_mode = 1;
        cfg_write(0, CFG_XPOS, 100);
        cfg_write(0, CFG_YPOS, 50);
        cfg_write(0, CFG_COLOUR, 6'b100100);
        cfg_write(0, CFG_CTRL, 1);
        foreach (ks[n]) begin
            prefetch(49 + ks[n]);
            checks++;
            if (addr_log[0] !== 6'(ks[n])) begin failures++; $display("[TB] FAIL single_rom_addr k=%0d got=%0d exp=%0d", ks[n], addr_log[0], ks[n]); end
            pixel(100 + ks[n], o, o2);
            checks++;
            if (o !== 6'b100100) begin failures++; $display("[TB] FAIL single_hit k=%0d got=%b exp=%b", ks[n], o, 6'b100100); end
            bad = 0;
            for (int xv = 90; xv <= 160; xv++) begin
                if (xv != 100 + ks[n]) begin
                    pixel(xv, o, o2);
                    if (o !== TRANSPARENT) bad++;
                end
            end
            checks++;
            if (bad !== 0) begin failures++; $display("[TB] FAIL single_others k=%0d bad=%0d exp=0", ks[n], bad); end
        end
    endtask

    task automatic test_priority();
        logic [5:0] o, o2;
        int xs[7] = '{205, 215, 247, 250, 257, 258, 199};
        logic [5:0] ex[7];
        ex = '{RED, RED, RED, WHITE, WHITE, TRANSPARENT, TRANSPARENT};
        do_reset();
        rom_mode = 2;
        cfg_write(0, CFG_XPOS, 200); cfg_write(0, CFG_YPOS, 200);
        cfg_write(0, CFG_COLOUR, RED); cfg_write(0, CFG_CTRL, 1);
        cfg_write(1, CFG_XPOS, 210); cfg_write(1, CFG_YPOS, 200);
        cfg_write(1, CFG_COLOUR, WHITE); cfg_write(1, CFG_CTRL, 1);
        prefetch(199);
        foreach (xs[n]) begin
            pixel(xs[n], o, o2);
            checks++;
            if (o !== ex[n]) begin failures++; $display("[TB] FAIL priority x=%0d got=%b exp=%b", xs[n], o, ex[n]); end
        end
        cfg_write(0, CFG_CTRL, 0);
        prefetch(199);
        pixel(215, o, o2);
        checks++;
        if (o !== WHITE) begin failures++; $display("[TB] FAIL priority_disabled x=215 got=%b exp=%b", o, WHITE); end
        pixel(205, o, o2);
        checks++;
        if (o !== TRANSPARENT) begin failures++; $display("[TB] FAIL priority_disabled x=205 got=%b exp=%b", o, TRANSPARENT); end
    endtask

    task automatic test_scale();
        logic [5:0] o, o2;
        logic [5:0] c = 6'b001100;
        do_reset();
        rom_mode = 3;
        cfg_write(0, CFG_XPOS, 0); cfg_write(0, CFG_YPOS, 0);
        cfg_write(0, CFG_COLOUR, c); cfg_write(0, CFG_CTRL, 1);
        prefetch(524);
        checks++;
        if (addr_log2[0] !== 6'd0) begin failures++; $display("[TB] FAIL scale_addr_line0 got=%0d exp=0", addr_log2[0]); end
        for (int xv = 0; xv < 3; xv++) begin
            pixel(xv, o, o2);
            checks++;
            if (o2 !== ((xv < 2) ? c : TRANSPARENT)) begin failures++; $display("[TB] FAIL scale_line0 x=%0d got=%b exp=%b", xv, o2, (xv < 2) ? c : TRANSPARENT); end
        end
        prefetch(0);
        checks++;
        if (addr_log2[0] !== 6'd0) begin failures++; $display("[TB] FAIL scale_addr_line1 got=%0d exp=0", addr_log2[0]); end
        for (int xv = 0; xv < 2; xv++) begin
            pixel(xv, o, o2);
            checks++;
            if (o2 !== c) begin failures++; $display("[TB] FAIL scale_line1 x=%0d got=%b exp=%b", xv, o2, c); end
        end
        prefetch(1);
        checks++;
        if (addr_log2[0] !== 6'd1) begin failures++; $display("[TB] FAIL scale_addr_line2 got=%0d exp=1", addr_log2[0]); end
        for (int xv = 1; xv < 5; xv++) begin
            pixel(xv, o, o2);
            checks++;
            if (o2 !== ((xv == 2 || xv == 3) ? c : TRANSPARENT)) begin failures++; $display("[TB] FAIL scale_line2 x=%0d got=%b exp=%b", xv, o2, (xv == 2 || xv == 3) ? c : TRANSPARENT); end
        end
    endtask

    task automatic test_motion();
        logic [5:0] o, o2;
        int on_x[4]  = '{592, 592, 591, 300};
        int off_x[4] = '{591, 593, 592, 299};
        do_reset();
        rom_mode = 4;
        cfg_write(0, CFG_XPOS, 591); cfg_write(0, CFG_YPOS, 0);
        cfg_write(0, CFG_COLOUR, WHITE); cfg_write(0, CFG_CTRL, 4'b0011);
        for (int f = 0; f < 4; f++) begin
            if (f == 3) begin
                cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = CFG_XPOS; cfg_data = 10'd300;
                frame_pulse();
                cfg_we = 1'b0;
            end else begin
                frame_pulse();
            end
            prefetch(19);
            pixel(on_x[f], o, o2);
            checks++;
            if (o !== WHITE) begin failures++; $display("[TB] FAIL motion_on frame=%0d x=%0d got=%b exp=%b", f + 1, on_x[f], o, WHITE); end
            pixel(off_x[f], o, o2);
            checks++;
            if (o !== TRANSPARENT) begin failures++; $display("[TB] FAIL motion_off frame=%0d x=%0d got=%b exp=%b", f + 1, off_x[f], o, TRANSPARENT); end
        end
        cfg_write(3, CFG_XPOS, 50);
        prefetch(19);
        pixel(300, o, o2);
        checks++;
        if (o !== WHITE) begin failures++; $display("[TB] FAIL bad_sel_ignored x=300 got=%b exp=%b", o, WHITE); end
        pixel(50, o, o2);
        checks++;
        if (o !== TRANSPARENT) begin failures++; $display("[TB] FAIL bad_sel_ignored x=50 got=%b exp=%b", o, TRANSPARENT); end
    endtask

    task automatic test_restart_reset();
        logic [5:0] o, o2;
        logic [5:0] seq [5];
        logic [5:0] ex [5];
        ex = '{6'd5, 6'd4, 6'd5, 6'd4, 6'd3};
        do_reset();
        rom_mode = 1;
        for (int s = 0; s < NUM_SPR; s++) begin
            cfg_write(s, CFG_XPOS, 100 * s);
            cfg_write(s, CFG_YPOS, s);
            cfg_write(s, CFG_COLOUR, RED);
            cfg_write(s, CFG_CTRL, 1);
        end
        y = 10'd4; line_end = 1'b1;
        tick();
        line_end = 1'b0;
        seq[0] = rom_addr;
        tick();
        seq[1] = rom_addr;
        line_end = 1'b1;
        tick();
        line_end = 1'b0;
        seq[2] = rom_addr;
        tick();
        seq[3] = rom_addr;
        tick();
        seq[4] = rom_addr;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (seq[i] !== ex[i]) begin failures++; $display("[TB] FAIL restart_seq step=%0d got=%0d exp=%0d", i, seq[i], ex[i]); end
        end
        checks++;
        if (rgb !== TRANSPARENT) begin failures++; $display("[TB] FAIL drain_reset_rgb got=%b exp=%b", rgb, TRANSPARENT); end
        checks++;
        if (rom_addr !== 6'd0) begin failures++; $display("[TB] FAIL drain_reset_rom_addr got=%0d exp=0", rom_addr); end
        cfg_write(0, CFG_CTRL, 1);
        cfg_write(1, CFG_XPOS, 100);
        cfg_write(1, CFG_CTRL, 1);
        pixel(5, o, o2);
        checks++;
        if (o !== TRANSPARENT) begin failures++; $display("[TB] FAIL rowbuf0_cleared got=%b exp=%b", o, TRANSPARENT); end
        pixel(104, o, o2);
        checks++;
        if (o !== TRANSPARENT) begin failures++; $display("[TB] FAIL rowbuf1_cleared got=%b exp=%b", o, TRANSPARENT); end
        prefetch(4);
        pixel(5, o, o2);
        checks++;
        if (o !== GOLD) begin failures++; $display("[TB] FAIL refetch_after_reset got=%b exp=%b", o, GOLD); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_scale();
        test_motion();
        test_restart_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
